// File: rtl/priority_resolver_isr.sv
// Priority resolver and in-service register for an 8259-compatible PIC.
// Picks the highest-priority unmasked request, runs the two-pulse INTA handshake and applies EOI commands.
module priority_resolver_isr #(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] IRR,
  input  logic [NUM_IR-1:0] interruptMask,
  input  logic              intaPulse,
  input  logic              autoEoi,
  input  logic              eoiValid,
  input  logic              eoiSpecific,
  input  logic              eoiRotate,
  input  logic [2:0]        eoiLevel,
  input  logic              setPriorityValid,
  input  logic              autoRotate,
  output logic              INT,
  output logic [NUM_IR-1:0] ISR,
  output logic [NUM_IR-1:0] clearIRR,
  output logic              vectorValid,
  output logic [2:0]        vectorLevel,
  output logic [2:0]        lowestPriority
);

  typedef enum logic {IDLE, ACK2} state_t;

  state_t            state, state_next;
  logic [NUM_IR-1:0] isr_q, isr_next;
  logic [NUM_IR-1:0] clear_q, clear_next;
  logic [2:0]        lowest_q, lowest_next;
  logic [2:0]        winner_q, winner_next;
  logic [2:0]        vlevel_q, vlevel_next;
  logic              spurious_q, spurious_next;
  logic              int_q, int_next;
  logic              vvalid_q, vvalid_next;

  logic [NUM_IR-1:0] eligible;
  logic              cand_found, isr_found, qualifies;
  logic [2:0]        cand_level, isr_level;

  // Rank 0 is the highest priority: the level just above the current lowest.
  function automatic logic [2:0] rank(input logic [2:0] level, input logic [2:0] low);
    return 3'(level - low - 3'd1);
  endfunction

  // Returns {found, level} of the highest-priority set bit of v.
  function automatic logic [3:0] find_top(input logic [NUM_IR-1:0] v, input logic [2:0] low);
    logic [3:0] result;
    logic [2:0] level;
    result = 4'd0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      level = 3'(low + 3'(i) + 3'd1);
      if (v[level]) result = {1'b1, level};
    end
    return result;
  endfunction

  assign eligible = IRR & ~interruptMask;

  always_comb begin
    {cand_found, cand_level} = find_top(eligible, lowest_q);
    {isr_found, isr_level}   = find_top(isr_q, lowest_q);
  end

  // Fully nested: a request only interrupts strictly lower-priority service.
  assign qualifies = cand_found &&
                     (!isr_found || (rank(cand_level, lowest_q) < rank(isr_level, lowest_q)));

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    state_next    = state;
    isr_next      = isr_q;
    lowest_next   = lowest_q;
    winner_next   = winner_q;
    spurious_next = spurious_q;
    vlevel_next   = vlevel_q;
    clear_next    = '0;
    vvalid_next   = 1'b0;
    int_next      = 1'b0;

    // EOI is judged on the pre-cycle ISR; INTA updates below are layered on top.
    if (eoiValid) begin
      if (eoiSpecific) begin
        isr_next[eoiLevel] = 1'b0;
        if (eoiRotate) lowest_next = eoiLevel;
      end else if (isr_found) begin
        isr_next[isr_level] = 1'b0;
        if (eoiRotate) lowest_next = isr_level;
      end
    end

    case (state)
      IDLE: begin
        if (intaPulse) begin
          state_next = ACK2;
          if (qualifies) begin
            winner_next          = cand_level;
            spurious_next        = 1'b0;
            isr_next[cand_level] = 1'b1;
            clear_next[cand_level] = 1'b1;
          end else begin
            winner_next   = 3'd7;
            spurious_next = 1'b1;
          end
        end else begin
          int_next = qualifies;
        end
      end
      ACK2: begin
        if (intaPulse) begin
          state_next  = IDLE;
          vvalid_next = 1'b1;
          vlevel_next = winner_q;
          if (autoEoi && !spurious_q) begin
            isr_next[winner_q] = 1'b0;
            if (autoRotate) lowest_next = winner_q;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (setPriorityValid) lowest_next = eoiLevel;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      isr_q      <= '0;
      clear_q    <= '0;
      lowest_q   <= 3'd7;
      winner_q   <= 3'd0;
      vlevel_q   <= 3'd0;
      spurious_q <= 1'b0;
      int_q      <= 1'b0;
      vvalid_q   <= 1'b0;
    end else begin
      state      <= state_next;
      isr_q      <= isr_next;
      clear_q    <= clear_next;
      lowest_q   <= lowest_next;
      winner_q   <= winner_next;
      vlevel_q   <= vlevel_next;
      spurious_q <= spurious_next;
      int_q      <= int_next;
      vvalid_q   <= vvalid_next;
    end
  end

  assign INT            = int_q;
  assign ISR            = isr_q;
  assign clearIRR       = clear_q;
  assign vectorValid    = vvalid_q;
  assign vectorLevel    = vlevel_q;
  assign lowestPriority = lowest_q;

endmodule

// File: tb/tb_priority_resolver_isr.sv
// Bench for priority_resolver_isr: directed vectors, with clearIRR/vector pulses checked by a queue-driven monitor.
module tb_priority_resolver_isr;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IRR, interruptMask;
  logic       intaPulse, autoEoi, eoiValid, eoiSpecific, eoiRotate;
  logic [2:0] eoiLevel;
  logic       setPriorityValid, autoRotate;
  logic       INT;
  logic [7:0] ISR, clearIRR;
  logic       vectorValid;
  logic [2:0] vectorLevel, lowestPriority;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_clr[$];
  logic [2:0] exp_vec[$];

  priority_resolver_isr dut (
    .clk(clk), .reset(reset), .IRR(IRR), .interruptMask(interruptMask),
    .intaPulse(intaPulse), .autoEoi(autoEoi), .eoiValid(eoiValid),
    .eoiSpecific(eoiSpecific), .eoiRotate(eoiRotate), .eoiLevel(eoiLevel),
    .setPriorityValid(setPriorityValid), .autoRotate(autoRotate),
    .INT(INT), .ISR(ISR), .clearIRR(clearIRR), .vectorValid(vectorValid),
    .vectorLevel(vectorLevel), .lowestPriority(lowestPriority)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic inta();
    intaPulse = 1'b1;
    step();
    intaPulse = 1'b0;
  endtask

  // Monitor: every clearIRR or vector pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (clearIRR != 8'h00) begin
      if (exp_clr.size() == 0) check("clear_irr_unexpected", clearIRR, 8'h00);
      else check("clear_irr", clearIRR, exp_clr.pop_front());
    end
    if (vectorValid) begin
      if (exp_vec.size() == 0) check("vector_unexpected", {7'd0, vectorValid}, 8'h00);
      else check("vector_level", {5'd0, vectorLevel}, {5'd0, exp_vec.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; IRR = 8'h00; interruptMask = 8'h00; intaPulse = 1'b0;
    autoEoi = 1'b0; eoiValid = 1'b0; eoiSpecific = 1'b0; eoiRotate = 1'b0;
    eoiLevel = 3'd0; setPriorityValid = 1'b0; autoRotate = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("reset_int", {7'd0, INT}, 8'h00);
    check("reset_isr", ISR, 8'h00);
    check("reset_clear", clearIRR, 8'h00);
    check("reset_vvalid", {7'd0, vectorValid}, 8'h00);
    check("reset_vlevel", {5'd0, vectorLevel}, 8'h00);
    check("reset_lowest", {5'd0, lowestPriority}, 8'h07);

    // Basic sequence: IR2 beats IR5.
    IRR = 8'h24;
    step();
    check("int_basic", {7'd0, INT}, 8'h01);
    exp_clr.push_back(8'h04);
    inta();
    check("isr_after_inta1", ISR, 8'h04);
    check("int_forced_low_ack2", {7'd0, INT}, 8'h00);
    IRR = 8'h20;
    step();
    check("clear_one_cycle", clearIRR, 8'h00);
    exp_vec.push_back(3'd2);
    inta();
    step();
    check("int_ir5_blocked_by_ir2", {7'd0, INT}, 8'h00);

    // Nesting: IR0 preempts IR2, IR3 does not.
    IRR = 8'h01;
    step();
    check("int_ir0_nests", {7'd0, INT}, 8'h01);
    IRR = 8'h08;
    step();
    check("int_ir3_blocked", {7'd0, INT}, 8'h00);

    // Masking.
    IRR = 8'h01; interruptMask = 8'h01;
    step();
    check("int_masked", {7'd0, INT}, 8'h00);
    interruptMask = 8'h00;
    step();
    check("int_unmasked", {7'd0, INT}, 8'h01);

    // Specific EOI clears IR2.
    IRR = 8'h00; eoiValid = 1'b1; eoiSpecific = 1'b1; eoiLevel = 3'd2;
    step();
    eoiValid = 1'b0; eoiSpecific = 1'b0;
    check("specific_eoi", ISR, 8'h00);

    // Build ISR = 0A: service IR3 then IR1.
    IRR = 8'h08;
    step();
    exp_clr.push_back(8'h08);
    inta();
    IRR = 8'h00;
    exp_vec.push_back(3'd3);
    inta();
    IRR = 8'h02;
    step();
    check("int_ir1_over_ir3", {7'd0, INT}, 8'h01);
    exp_clr.push_back(8'h02);
    inta();
    check("isr_0a", ISR, 8'h0A);
    IRR = 8'h00;
    exp_vec.push_back(3'd1);
    inta();

    // Non-specific rotating EOI: clears IR1, lowest becomes 1.
    eoiValid = 1'b1; eoiRotate = 1'b1;
    step();
    eoiValid = 1'b0; eoiRotate = 1'b0;
    check("nseoi_isr", ISR, 8'h08);
    check("nseoi_lowest", {5'd0, lowestPriority}, 8'h01);
    IRR = 8'h05;
    step();
    check("int_after_rotate", {7'd0, INT}, 8'h01);
    exp_clr.push_back(8'h04);
    inta();
    check("isr_ir2_selected", ISR, 8'h0C);
    IRR = 8'h01;
    exp_vec.push_back(3'd2);
    inta();

    // Auto-EOI with auto-rotate, starting from lowest = 3.
    reset = 1'b1; IRR = 8'h00;
    step();
    reset = 1'b0;
    setPriorityValid = 1'b1; eoiLevel = 3'd3;
    step();
    setPriorityValid = 1'b0;
    check("set_priority", {5'd0, lowestPriority}, 8'h03);
    autoEoi = 1'b1; autoRotate = 1'b1; IRR = 8'h80;
    step();
    check("int_ir7", {7'd0, INT}, 8'h01);
    exp_clr.push_back(8'h80);
    inta();
    check("isr_ir7", ISR, 8'h80);
    IRR = 8'h00;
    exp_vec.push_back(3'd7);
    inta();
    check("aeoi_isr", ISR, 8'h00);
    check("aeoi_lowest", {5'd0, lowestPriority}, 8'h07);
    autoEoi = 1'b0; autoRotate = 1'b0;

    // Spurious INTA.
    inta();
    check("spurious_isr", ISR, 8'h00);
    check("spurious_clear", clearIRR, 8'h00);
    exp_vec.push_back(3'd7);
    inta();
    check("spurious_isr_after", ISR, 8'h00);

    // Same-cycle specific EOI and INTA on IR4: the set wins.
    IRR = 8'h10;
    step();
    exp_clr.push_back(8'h10);
    eoiValid = 1'b1; eoiSpecific = 1'b1; eoiLevel = 3'd4;
    inta();
    eoiValid = 1'b0; eoiSpecific = 1'b0;
    check("eoi_inta_same_bit", ISR, 8'h10);
    IRR = 8'h00;
    exp_vec.push_back(3'd4);
    inta();

    // Reset while in ACK2 aborts the sequence.
    IRR = 8'h01;
    step();
    exp_clr.push_back(8'h01);
    inta();
    check("isr_before_abort", ISR, 8'h11);
    reset = 1'b1; IRR = 8'h00;
    step();
    reset = 1'b0;
    check("abort_isr", ISR, 8'h00);
    check("abort_int", {7'd0, INT}, 8'h00);
    IRR = 8'h02;
    step();
    check("abort_back_in_idle", {7'd0, INT}, 8'h01);
    IRR = 8'h00;
    inta();
    check("abort_no_vector", {7'd0, vectorValid}, 8'h00);
    step();
    check("abort_no_vector_late", {7'd0, vectorValid}, 8'h00);

    check("clear_queue_drained", 8'(exp_clr.size()), 8'h00);
    check("vector_queue_drained", 8'(exp_vec.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
